// File: rtl/axi4_burst_pkg.sv
// Shared types and constants for the AXI4 stream-to-burst write path.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package axi4_burst_pkg;

    // AXI write response codes
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Fixed 4-byte beats, incrementing bursts
    localparam logic [2:0] AWSIZE_4B  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Writer job sequencing
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE
    } wr_state_t;

    // AWLEN for the next burst: min(burst_len, remaining) - 1.
    // Returns 0 when nothing remains so the register never holds a wrapped value.
    function automatic logic [7:0] calc_awlen(input logic [31:0] remaining,
                                              input int unsigned burst_len);
        if (remaining == 32'd0) begin
            return 8'd0;
        end else if (remaining >= burst_len) begin
            return 8'(burst_len - 1);
        end else begin
            return 8'(remaining - 32'd1);
        end
    endfunction

endpackage

// File: rtl/axi4_beat_counter.sv
// Counts accepted W beats within one burst; flags the final beat.
// Latency: last is combinational from the count; done = inc on the last beat.
// Backpressure: none; counts only when inc (a W handshake) is asserted.
module axi4_beat_counter import axi4_burst_pkg::*; #(
    parameter int CNT_W = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             inc,
    output logic             last,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;

    // Restart the count and capture the burst length whenever a new burst is issued
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= len;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == len_q);
    assign done = inc && last;

endmodule

// File: rtl/axi4_stream_burst_writer.sv
// Packs a 32-bit stream into INCR write bursts (AW/W/B only) starting at an aligned base.
// Latency: AW one cycle after start; W beats pass straight through from the stream.
// Backpressure: s_tready follows WREADY only during the data phase; optional
// AXI4_STREAM_BURST_WRITER_ERRCNT_EN adds a saturating err_count output.
module axi4_stream_burst_writer import axi4_burst_pkg::*; #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int LEN_W     = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef AXI4_STREAM_BURST_WRITER_ERRCNT_EN
    output logic [7:0]        err_count,
`endif
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [7:0]        M_AXI_AWLEN,
    output logic [2:0]        M_AXI_AWSIZE,
    output logic [1:0]        M_AXI_AWBURST,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [DATA_W-1:0] M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WLAST,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY
);

    // Base is forced to a full-burst boundary, so no burst can straddle 4 KB
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN * 4 - 1);

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [7:0]        aw_len_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  beats;
    logic [LEN_W-1:0]  rem_after;
    logic [ADDR_W-1:0] addr_after;
    logic              start_ok;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              beat_last;
    logic              burst_end;
    logic              bad_resp;

    // Handshakes decoded from state directly so the FSM has no combinational loop
    assign start_ok   = start && (state == IDLE);
    assign aw_hs      = (state == ADDR) && M_AXI_AWREADY;
    assign w_hs       = (state == DATA) && s_tvalid && M_AXI_WREADY;
    assign b_hs       = (state == RESP) && M_AXI_BVALID;
    assign bad_resp   = (resp_t'(M_AXI_BRESP) != OKAY);
    assign beats      = LEN_W'(aw_len_q) + 1'b1;
    assign rem_after  = rem_q - beats;
    assign addr_after = aw_addr_q + ADDR_W'({beats, 2'b00});

    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWLEN   = aw_len_q;
    assign M_AXI_AWSIZE  = AWSIZE_4B;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_WDATA   = s_tdata;
    assign M_AXI_WSTRB   = 4'hF;

    axi4_beat_counter #(.CNT_W(8)) u_beat_cnt (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .load   (aw_hs),
        .len    (aw_len_q),
        .inc    (w_hs),
        .last   (beat_last),
        .done   (burst_end)
    );

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and channel valid/ready decode
    always_comb begin
        state_nxt     = state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        s_tready      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_words == '0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                M_AXI_WVALID = s_tvalid;
                M_AXI_WLAST  = beat_last;
                s_tready     = M_AXI_WREADY;
                if (burst_end) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    state_nxt = (rem_after == '0) ? DONE : ADDR;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job bookkeeping: address/length for the next burst, remaining words, status flags
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            rem_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                busy <= 1'b0;
            end
            if (start_ok) begin
                busy      <= 1'b1;
                err       <= 1'b0;
                rem_q     <= num_words;
                aw_addr_q <= base_addr & ALIGN_MASK;
                aw_len_q  <= calc_awlen(32'(num_words), BURST_LEN);
            end
            if (b_hs) begin
                if (bad_resp) begin
                    err <= 1'b1;
                end
                rem_q     <= rem_after;
                aw_addr_q <= addr_after;
                aw_len_q  <= calc_awlen(32'(rem_after), BURST_LEN);
            end
        end
    end

`ifdef AXI4_STREAM_BURST_WRITER_ERRCNT_EN
    // Per-job count of error responses, saturating
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_count <= 8'd0;
        end else if (start_ok) begin
            err_count <= 8'd0;
        end else if (b_hs && bad_resp && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_stream_burst_writer.sv
// Bench for axi4_stream_burst_writer: AXI slave model, stream source and burst scoreboard.
// Expected AW and W beats are queued at job launch and popped at each handshake.
module tb_axi4_stream_burst_writer;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy, done, err;
`ifdef AXI4_STREAM_BURST_WRITER_ERRCNT_EN
    logic [7:0]  err_count;
`endif
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;

    always #5 ACLK = ~ACLK;

    axi4_stream_burst_writer dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .err           (err),
`ifdef AXI4_STREAM_BURST_WRITER_ERRCNT_EN
        .err_count     (err_count),
`endif
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct { logic [31:0] data; logic last; } w_exp_t;

    aw_exp_t     exp_aw[$];
    w_exp_t      exp_w[$];
    logic [31:0] stream_q[$];
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int bad   = 0;

    // slave / source configuration and monitor state
    int          aw_stall   = 0;
    bit          w_toggle   = 0;
    bit          gap_en     = 0;
    int          bad_burst  = 0;
    int          b_idx      = 1;
    int          b_pending  = 0;
    int          b_cnt      = 0;
    int          aw_cnt     = 0;
    int          done_cnt   = 0;
    int          w_hs_total = 0;
    bit          aw_open    = 0;
    int          beat       = 0;
    logic [31:0] cur_addr   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor at negedge, then drive slave/stream inputs just after posedge
    initial begin : slave_and_monitor
        bit          stream_acc;
        bit          b_fire;
        bit          aw_prev_wait;
        logic [31:0] aw_prev_addr;
        logic [7:0]  aw_prev_len;
        int          aw_wait;
        aw_exp_t     ea;
        w_exp_t      ew;
        s_tvalid = 0; s_tdata = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        b_fire = 0; aw_prev_wait = 0; aw_prev_addr = 0; aw_prev_len = 0; aw_wait = 0;
        forever begin
            @(negedge ACLK);
            stream_acc = s_tvalid && s_tready;
            if (M_AXI_AWVALID && aw_prev_wait) begin
                check("aw_addr_stable", M_AXI_AWADDR, aw_prev_addr);
                check("aw_len_stable", M_AXI_AWLEN, aw_prev_len);
            end
            aw_prev_wait = M_AXI_AWVALID && !M_AXI_AWREADY;
            aw_prev_addr = M_AXI_AWADDR;
            aw_prev_len  = M_AXI_AWLEN;
            if (M_AXI_WVALID) check("w_after_aw", aw_open, 1);
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_hs_total++;
                if (exp_w.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    ew = exp_w.pop_front();
                    check("w_data", M_AXI_WDATA, ew.data);
                    check("w_last", M_AXI_WLAST, ew.last);
                    mem[cur_addr + 32'(beat * 4)] = M_AXI_WDATA;
                    beat++;
                    if (ew.last) begin
                        aw_open = 0;
                        b_pending++;
                    end
                end
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_cnt++;
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 1, 0);
                end else begin
                    ea = exp_aw.pop_front();
                    check("aw_addr", M_AXI_AWADDR, ea.addr);
                    check("aw_len", M_AXI_AWLEN, ea.len);
                end
                aw_open  = 1;
                beat     = 0;
                cur_addr = M_AXI_AWADDR;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                b_fire = 1;
                b_cnt++;
            end
            if (done) done_cnt++;

            @(posedge ACLK);
            #1;
            if (stream_acc && stream_q.size() > 0) void'(stream_q.pop_front());
            s_tvalid = (stream_q.size() > 0) && !(gap_en && ($urandom_range(0, 3) == 0));
            s_tdata  = (stream_q.size() > 0) ? stream_q[0] : 32'h0;
            if (aw_stall == 0) begin
                M_AXI_AWREADY = 1;
            end else if (M_AXI_AWVALID) begin
                if (aw_wait >= aw_stall) begin
                    M_AXI_AWREADY = 1;
                end else begin
                    M_AXI_AWREADY = 0;
                    aw_wait++;
                end
            end else begin
                M_AXI_AWREADY = 0;
                aw_wait = 0;
            end
            M_AXI_WREADY = w_toggle ? !M_AXI_WREADY : 1'b1;
            if (b_fire) begin
                M_AXI_BVALID = 0;
                b_fire = 0;
            end
            if (!M_AXI_BVALID && b_pending > 0) begin
                M_AXI_BVALID = 1;
                M_AXI_BRESP  = (b_idx == bad_burst) ? 2'b10 : 2'b00;
                b_idx++;
                b_pending--;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    // Queue expectations and stream words for one job, then launch it
    task automatic launch(input logic [31:0] base, input int n, input int seed);
        logic [31:0] addr;
        int          rem, b, k;
        aw_exp_t     ea;
        w_exp_t      ew;
        addr = base & ~32'h1F;
        rem  = n;
        k    = 0;
        while (rem > 0) begin
            b = (rem > 8) ? 8 : rem;
            ea.addr = addr;
            ea.len  = 8'(b - 1);
            exp_aw.push_back(ea);
            for (int j = 0; j < b; j++) begin
                ew.data = 32'(seed * 256 + k + 1);
                ew.last = (j == b - 1);
                exp_w.push_back(ew);
                stream_q.push_back(ew.data);
                k++;
            end
            addr = addr + 32'(b * 4);
            rem  = rem - b;
        end
        start = 1; base_addr = base; num_words = 16'(n);
        tick();
        start = 0;
    endtask

    task automatic run_job(input logic [31:0] base, input int n, input int seed,
                           input int stall, input bit toggle, input int bad_b, input bit exp_err);
        int          done0, c;
        bit          seen;
        logic [31:0] a;
        aw_stall = stall; w_toggle = toggle; bad_burst = bad_b;
        b_idx = 1; b_cnt = 0; aw_cnt = 0;
        mem.delete();
        done0 = done_cnt;
        launch(base, n, seed);
        @(negedge ACLK);
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
`ifdef AXI4_STREAM_BURST_WRITER_ERRCNT_EN
        check("err_count_cleared", err_count, 0);
`endif
        seen = 0;
        c = 0;
        while (!seen && c < 3000) begin
            @(negedge ACLK);
            c++;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        if (n == 0) check("zero_done_latency", c, 1);
        check("busy_at_done", busy, 0);
        check("err_at_done", err, exp_err);
`ifdef AXI4_STREAM_BURST_WRITER_ERRCNT_EN
        check("err_count_at_done", err_count, exp_err ? 1 : 0);
`endif
        check("aw_count", aw_cnt, (n + 7) / 8);
        check("b_count", b_cnt, (n + 7) / 8);
        check("w_left", exp_w.size(), 0);
        check("aw_left", exp_aw.size(), 0);
        repeat (4) tick();
        check("done_pulses", done_cnt - done0, 1);
        a = base & ~32'h1F;
        for (int i = 0; i < n; i++) begin
            check("readback", mem.exists(a) ? mem[a] : 32'hDEADBEEF, 32'(seed * 256 + i + 1));
            a = a + 32'd4;
        end
    endtask

    initial begin : main
        int w0, c;
        ARESET = 1; start = 0; base_addr = 0; num_words = 0;
        repeat (3) tick();
        @(negedge ACLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_awvalid", M_AXI_AWVALID, 0);
        check("rst_wvalid", M_AXI_WVALID, 0);
        check("rst_wlast", M_AXI_WLAST, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_tready", s_tready, 0);
        check("rst_awaddr", M_AXI_AWADDR, 0);
        check("rst_awlen", M_AXI_AWLEN, 0);
        check("awsize", M_AXI_AWSIZE, 3'b010);
        check("awburst", M_AXI_AWBURST, 2'b01);
        check("wstrb", M_AXI_WSTRB, 4'hF);
`ifdef AXI4_STREAM_BURST_WRITER_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif
        tick();
        ARESET = 0;
        tick();

        run_job(32'h0000_0000, 8, 0, 0, 0, 0, 0);
        gap_en = 1;
        run_job(32'h0000_0040, 20, 1, 0, 0, 0, 0);
        gap_en = 0;
        run_job(32'h0000_030C, 8, 2, 10, 1, 0, 0);
        run_job(32'h0000_0200, 20, 3, 0, 0, 2, 1);
        run_job(32'h0000_0000, 0, 4, 0, 0, 0, 0);

        // Abandon a burst with reset while its 4th beat is on the bus
        aw_stall = 0; w_toggle = 0; bad_burst = 0; b_idx = 1;
        w0 = w_hs_total;
        launch(32'h0000_0100, 8, 9);
        c = 0;
        while ((w_hs_total - w0) < 3 && c < 500) begin
            @(negedge ACLK);
            c++;
        end
        check("reset_reach_beat4", w_hs_total - w0, 3);
        @(posedge ACLK);
        #2;
        ARESET = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        check("mid_rst_awvalid", M_AXI_AWVALID, 0);
        check("mid_rst_wvalid", M_AXI_WVALID, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bready", M_AXI_BREADY, 0);
        check("mid_rst_tready", s_tready, 0);
        tick();
        ARESET = 0;
        stream_q.delete();
        exp_w.delete();
        exp_aw.delete();
        aw_open = 0;
        b_pending = 0;
        tick();
        run_job(32'h0000_0180, 8, 5, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
